muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_if.sv | 45 ++++
 rtl/muldiv_ctrl.sv | 149 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: pipeline <-> multiply/divide unit bundle.
// Request, HI/LO read port and status lines.
interface muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             mul0_div1_sel;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             hilo_rd;
  logic             hi0_lo1_sel;
  logic [WIDTH-1:0] hilo_out;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start,
    output mul0_div1_sel,
    output opa,
    output opb,
    output hilo_rd,
    output hi0_lo1_sel,
    input  hilo_out,
    input  busy,
    input  stall,
    input  done,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  mul0_div1_sel,
    input  opa,
    input  opb,
    input  hilo_rd,
    input  hi0_lo1_sel,
    output hilo_out,
    output busy,
    output stall,
    output done,
    output div_by_zero
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative unsigned multiply/divide with HI/LO
// result registers and pipeline stall generation.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  muldiv_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int AW = 2 * WIDTH;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [AW-1:0]    acc_q;
  logic [AW-1:0]    acc_d;
  logic [WIDTH-1:0] arg_q;
  logic [WIDTH-1:0] arg_d;
  logic             op_div_q;
  logic             op_div_d;
  logic             dz_q;
  logic             dz_d;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] hi_d;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] lo_d;
  logic             done_q;
  logic             done_d;
  logic             dbz_q;
  logic             dbz_d;

  // acc holds {partial, multiplier} or {remainder, quotient}
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [AW-1:0]    div_next;
  logic [AW-1:0]    step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[AW-1:WIDTH]}
             + {1'b0, (acc_q[0] ? arg_q : '0)};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  // Borrow out of the top bit means the trial subtract failed.
  always_comb begin
    div_shift = acc_q[AW-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, arg_q};
    if (div_diff[WIDTH]) begin
      div_next = {div_shift[WIDTH-1:0],
                  acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_diff[WIDTH-1:0],
                  acc_q[WIDTH-2:0], 1'b1};
    end
  end

  assign step = op_div_q ? div_next : mul_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      arg_q    <= '0;
      op_div_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      arg_q    <= arg_d;
      op_div_q <= op_div_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    arg_d    = arg_q;
    op_div_d = op_div_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (bus.start) begin
          state_d  = RUN;
          cnt_d    = CW'(WIDTH - 1);
          op_div_d = bus.mul0_div1_sel;
          dz_d     = bus.mul0_div1_sel
                   && (bus.opb == '0);
          dbz_d    = 1'b0;
          if (bus.mul0_div1_sel) begin
            arg_d = bus.opb;
            acc_d = {{WIDTH{1'b0}}, bus.opa};
          end else begin
            arg_d = bus.opa;
            acc_d = {{WIDTH{1'b0}}, bus.opb};
          end
        end
      end
      (state_q == RUN): begin
        acc_d = step;
        if (cnt_q == '0) begin
          state_d = IDLE;
          hi_d    = step[AW-1:WIDTH];
          lo_d    = step[WIDTH-1:0];
          done_d  = 1'b1;
          dbz_d   = dz_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.stall       = bus.busy
                         & (bus.hilo_rd | bus.start);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hilo_out    = bus.hi0_lo1_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed checks of muldiv_ctrl at WIDTH=32.
// Each task drives a scenario and compares inline.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  muldiv_ctrl_if #(.WIDTH(W)) m ();

  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hilo(output logic [W-1:0] hi,
                           output logic [W-1:0] lo);
    m.hi0_lo1_sel = 1'b0;
    #1;
    hi = m.hilo_out;
    m.hi0_lo1_sel = 1'b1;
    #1;
    lo = m.hilo_out;
  endtask

  // Issues one op and watches WIDTH+4 cycles from N+1.
  task automatic run_op(input logic sel,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        output int bc,
                        output int dc,
                        output int di);
    m.start = 1'b1;
    m.mul0_div1_sel = sel;
    m.opa = a;
    m.opb = b;
    tick();
    m.start = 1'b0;
    bc = 0;
    dc = 0;
    di = -1;
    for (int i = 0; i < W + 4; i++) begin
      if (m.busy) bc++;
      if (m.done) begin
        dc++;
        di = i;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] hi, lo;
    rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if (m.busy !== 1'b0 || m.done !== 1'b0 ||
        m.div_by_zero !== 1'b0 || m.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags got busy=%b done=%b dbz=%b stall=%b exp 0000",
               m.busy, m.done, m.div_by_zero, m.stall);
    end
    read_hilo(hi, lo);
    n_chk++;
    if (hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL reset_hilo got %h_%h exp 0_0", hi, lo);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mul_small();
    int bc, dc, di;
    logic [W-1:0] hi, lo;
    run_op(1'b0, 32'd7, 32'd6, bc, dc, di);
    n_chk++;
    if (bc !== W) begin
      n_fail++;
      $display("FAIL mul_busy_cycles got %0d exp %0d", bc, W);
    end
    n_chk++;
    if (dc !== 1 || di !== W) begin
      n_fail++;
      $display("FAIL mul_done_pulse got cnt=%0d at=%0d exp cnt=1 at=%0d",
               dc, di, W);
    end
    read_hilo(hi, lo);
    n_chk++;
    if (hi !== 32'h0 || lo !== 32'h2A) begin
      n_fail++;
      $display("FAIL mul_7x6 got %h_%h exp 00000000_0000002a", hi, lo);
    end
  endtask

  task automatic test_mul_max();
    int bc, dc, di;
    logic [W-1:0] hi, lo;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc, di);
    read_hilo(hi, lo);
    n_chk++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin
      n_fail++;
      $display("FAIL mul_max got %h_%h exp fffffffe_00000001", hi, lo);
    end
  endtask

  task automatic test_div();
    int bc, dc, di;
    logic [W-1:0] hi, lo;
    run_op(1'b1, 32'd100, 32'd7, bc, dc, di);
    read_hilo(hi, lo);
    n_chk++;
    if (hi !== 32'd2 || lo !== 32'd14 || m.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL div_100_7 got %h_%h dbz=%b exp 2_e dbz=0",
               hi, lo, m.div_by_zero);
    end
    run_op(1'b1, 32'd3, 32'd10, bc, dc, di);
    read_hilo(hi, lo);
    n_chk++;
    if (hi !== 32'd3 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL div_3_10 got %h_%h exp 3_0", hi, lo);
    end
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, bc, dc, di);
    read_hilo(hi, lo);
    n_chk++;
    if (hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL div_max_1 got %h_%h exp 0_ffffffff", hi, lo);
    end
    run_op(1'b1, 32'd5, 32'd0, bc, dc, di);
    read_hilo(hi, lo);
    n_chk++;
    if (bc !== W || dc !== 1) begin
      n_fail++;
      $display("FAIL div0_timing got busy=%0d done=%0d exp %0d 1",
               bc, dc, W);
    end
    n_chk++;
    if (hi !== 32'd5 || lo !== 32'hFFFF_FFFF ||
        m.div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL div_5_0 got %h_%h dbz=%b exp 5_ffffffff dbz=1",
               hi, lo, m.div_by_zero);
    end
    m.start = 1'b1;
    m.mul0_div1_sel = 1'b0;
    m.opa = 32'd3;
    m.opb = 32'd4;
    #1;
    n_chk++;
    if (m.div_by_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_sticky got %b exp 1", m.div_by_zero);
    end
    tick();
    m.start = 1'b0;
    n_chk++;
    if (m.div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dbz_clear got %b exp 0", m.div_by_zero);
    end
    for (int i = 0; i < W + 2; i++) tick();
    read_hilo(hi, lo);
    n_chk++;
    if (lo !== 32'd12 || hi !== 32'd0) begin
      n_fail++;
      $display("FAIL mul_3x4 got %h_%h exp 0_c", hi, lo);
    end
  endtask

  task automatic test_stall_read();
    int sc;
    int hold_err;
    m.start = 1'b1;
    m.mul0_div1_sel = 1'b0;
    m.opa = 32'd9;
    m.opb = 32'd9;
    tick();
    m.start = 1'b0;
    m.hilo_rd = 1'b1;
    m.hi0_lo1_sel = 1'b1;
    #1;
    sc = 0;
    hold_err = 0;
    for (int i = 0; i < W; i++) begin
      if (m.stall === 1'b1) sc++;
      if (m.hilo_out !== 32'd12) hold_err++;
      tick();
    end
    n_chk++;
    if (sc !== W) begin
      n_fail++;
      $display("FAIL rd_stall_cycles got %0d exp %0d", sc, W);
    end
    n_chk++;
    if (hold_err !== 0) begin
      n_fail++;
      $display("FAIL rd_hold_old got %0d bad cycles exp 0", hold_err);
    end
    n_chk++;
    if (m.stall !== 1'b0 || m.hilo_out !== 32'd81) begin
      n_fail++;
      $display("FAIL rd_after got stall=%b lo=%h exp 0 51",
               m.stall, m.hilo_out);
    end
    m.hilo_rd = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] hi, lo;
    m.start = 1'b1;
    m.mul0_div1_sel = 1'b0;
    m.opa = 32'd10;
    m.opb = 32'd11;
    tick();
    m.start = 1'b0;
    for (int k = 2; k <= 33; k++) begin
      tick();
      if (k == 5) begin
        m.start = 1'b1;
        m.opa = 32'd2;
        m.opb = 32'd3;
        #1;
        n_chk++;
        if (m.stall !== 1'b1 || m.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_stall got stall=%b busy=%b exp 1 1",
                   m.stall, m.busy);
        end
      end
    end
    m.hilo_rd = 1'b1;
    m.hi0_lo1_sel = 1'b1;
    #1;
    n_chk++;
    if (m.done !== 1'b1 || m.busy !== 1'b0 ||
        m.stall !== 1'b0 || m.hilo_out !== 32'd110) begin
      n_fail++;
      $display("FAIL b2b_done got done=%b busy=%b stall=%b lo=%h exp 1 0 0 6e",
               m.done, m.busy, m.stall, m.hilo_out);
    end
    tick();
    m.start = 1'b0;
    m.hilo_rd = 1'b0;
    n_chk++;
    if (m.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept got busy=%b exp 1", m.busy);
    end
    for (int i = 0; i < W + 2; i++) tick();
    read_hilo(hi, lo);
    n_chk++;
    if (lo !== 32'd6 || hi !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_second got %h_%h exp 0_6", hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] hi, lo;
    int dc, bc;
    m.start = 1'b1;
    m.mul0_div1_sel = 1'b0;
    m.opa = 32'd7;
    m.opb = 32'd6;
    tick();
    m.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if (m.busy !== 1'b0 || m.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_busy got busy=%b done=%b exp 0 0",
               m.busy, m.done);
    end
    read_hilo(hi, lo);
    n_chk++;
    if (hi !== '0 || lo !== '0) begin
      n_fail++;
      $display("FAIL abort_hilo got %h_%h exp 0_0", hi, lo);
    end
    dc = 0;
    bc = 0;
    for (int i = 0; i < W + 8; i++) begin
      if (m.done) dc++;
      if (m.busy) bc++;
      tick();
    end
    n_chk++;
    if (dc !== 0 || bc !== 0) begin
      n_fail++;
      $display("FAIL abort_quiet got done=%0d busy=%0d exp 0 0", dc, bc);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    m.start = 1'b0;
    m.mul0_div1_sel = 1'b0;
    m.opa = '0;
    m.opb = '0;
    m.hilo_rd = 1'b0;
    m.hi0_lo1_sel = 1'b0;
    test_reset();
    test_mul_small();
    test_mul_max();
    test_div();
    test_stall_read();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
